// File: rtl/mux_sel_sequencer.sv
// Byte-to-serial sequencer that steps the select of an external 8:1 mux
// and registers the returned bit onto a valid/ready serial stream.
module mux_sel_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic [7:0] data_reg,
    output logic [2:0] sel,
    input  logic       mux_out,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_data,
    output logic       ser_last
);

    localparam logic [2:0] START = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] END   = MSB_FIRST ? 3'd0 : 3'd7;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic advance;
    logic at_end;

    assign at_end  = (sel == END);
    assign accept  = load_valid && load_ready;
    assign advance = (state == SCAN) && (!ser_valid || ser_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = SCAN;
            SCAN: if (advance && at_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == IDLE);
    end

    // The output slot drains in IDLE too, so the last bit of a byte may still
    // be pending while the next byte is being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= 8'h00;
            sel       <= 3'd0;
            ser_valid <= 1'b0;
            ser_data  <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            if (accept) begin
                data_reg <= load_data;
                sel      <= START;
            end
            if (advance) begin
                ser_data  <= mux_out;
                ser_valid <= 1'b1;
                ser_last  <= at_end;
                if (!at_end) begin
                    if (MSB_FIRST) begin
                        sel <= sel - 3'd1;
                    end else begin
                        sel <= sel + 3'd1;
                    end
                end
            end else if (ser_valid && ser_ready) begin
                ser_valid <= 1'b0;
                ser_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: an LSB-first and an MSB-first sequencer share one stimulus
// stream, each looped back through a behavioural 8:1 mux.
module tb_mux_sel_sequencer;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       ser_ready;

    logic       load_ready [2];
    logic [7:0] data_reg   [2];
    logic [2:0] sel        [2];
    logic       mux_out    [2];
    logic       ser_valid  [2];
    logic       ser_data   [2];
    logic       ser_last   [2];

    int checks;
    int passes;
    int fails;

    // Reference model: byte-level view of the sequencer
    bit         m_idle;
    int         m_rem;
    bit         m_slot_valid;
    logic [7:0] m_data;
    logic [2:0] m_sel [2];
    int         accept_count;
    logic [1:0] exp_q0 [$];
    logic [1:0] exp_q1 [$];

    assign mux_out[0] = data_reg[0][sel[0]];
    assign mux_out[1] = data_reg[1][sel[1]];

    mux_sel_sequencer #(.MSB_FIRST(1'b0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready[0]),
        .load_data  (load_data),
        .data_reg   (data_reg[0]),
        .sel        (sel[0]),
        .mux_out    (mux_out[0]),
        .ser_valid  (ser_valid[0]),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data[0]),
        .ser_last   (ser_last[0])
    );

    mux_sel_sequencer #(.MSB_FIRST(1'b1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready[1]),
        .load_data  (load_data),
        .data_reg   (data_reg[1]),
        .sel        (sel[1]),
        .mux_out    (mux_out[1]),
        .ser_valid  (ser_valid[1]),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data[1]),
        .ser_last   (ser_last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    task automatic model_reset();
        m_idle       = 1'b1;
        m_rem        = 0;
        m_slot_valid = 1'b0;
        m_data       = 8'h00;
        m_sel[0]     = 3'd0;
        m_sel[1]     = 3'd0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_step();
        if (m_idle) begin
            if (m_slot_valid && ser_ready) m_slot_valid = 1'b0;
            if (load_valid) begin
                m_idle   = 1'b0;
                m_rem    = 8;
                m_data   = load_data;
                m_sel[0] = 3'd0;
                m_sel[1] = 3'd7;
                for (int i = 0; i < 8; i++) begin
                    exp_q0.push_back({load_data[i], (i == 7)});
                    exp_q1.push_back({load_data[7 - i], (i == 7)});
                end
                accept_count++;
            end
        end else if (!m_slot_valid || ser_ready) begin
            m_slot_valid = 1'b1;
            m_rem--;
            if (m_rem == 0) begin
                m_idle = 1'b1;
            end else begin
                m_sel[0] = 3'(8 - m_rem);
                m_sel[1] = 3'(m_rem - 1);
            end
        end
    endtask

    task automatic compare_dut(input int d);
        logic [1:0] e;
        checkOutput("load_ready", d, {7'd0, load_ready[d]}, {7'd0, m_idle});
        checkOutput("ser_valid", d, {7'd0, ser_valid[d]}, {7'd0, m_slot_valid});
        checkOutput("sel", d, {5'd0, sel[d]}, {5'd0, m_sel[d]});
        checkOutput("data_reg", d, data_reg[d], m_data);
        if (!ser_valid[d]) checkOutput("idle_last", d, {7'd0, ser_last[d]}, 8'd0);
        if (ser_valid[d] && ser_ready) begin
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                checkOutput("unexpected_bit", d, 8'd1, 8'd0);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                checkOutput("ser_data", d, {7'd0, ser_data[d]}, {7'd0, e[1]});
                checkOutput("ser_last", d, {7'd0, ser_last[d]}, {7'd0, e[0]});
            end
        end
    endtask

    // Monitor: compare on the falling edge, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        compare_dut(0);
        compare_dut(1);
        if (rst_n) model_step();
    end

    task automatic applyStimulus(input logic [7:0] data, input bit hold);
        int start;
        bit found;
        start      = accept_count;
        found      = 1'b0;
        load_valid = 1'b1;
        load_data  = data;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (accept_count != start) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("accept_timeout", 0, {7'd0, found}, 8'd1);
        #1;
        if (!hold) load_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_ready", d, {7'd0, load_ready[d]}, 8'd1);
            checkOutput("rst_valid", d, {7'd0, ser_valid[d]}, 8'd0);
            checkOutput("rst_data", d, {7'd0, ser_data[d]}, 8'd0);
            checkOutput("rst_last", d, {7'd0, ser_last[d]}, 8'd0);
            checkOutput("rst_sel", d, {5'd0, sel[d]}, 8'd0);
            checkOutput("rst_data_reg", d, data_reg[d], 8'h00);
        end
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        fails        = 0;
        accept_count = 0;
        model_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        ser_ready  = 1'b1;
        #2;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(8'hA5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(8'hC3, 1'b0);
        repeat (10) @(posedge clk);
        #1;

        // Stall the consumer for three cycles once the second bit is presented
        applyStimulus(8'h6D, 1'b0);
        repeat (2) @(posedge clk);
        #1 ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ser_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        applyStimulus(8'h0F, 1'b1);
        applyStimulus(8'hF0, 1'b0);
        repeat (10) @(posedge clk);
        #1;

        applyStimulus(8'hFF, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // A load offered mid-scan must be ignored
        applyStimulus(8'h81, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_data  = 8'h3C;
        repeat (3) @(posedge clk);
        #1 load_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        for (int c = 0; c < 400; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 8'($urandom);
            ser_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        load_valid = 1'b0;
        ser_ready  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("drain_q0", 0, 8'(exp_q0.size()), 8'd0);
        checkOutput("drain_q1", 1, 8'(exp_q1.size()), 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
